// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_port_arbiter: arbitration states, master indices
// and default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int STAT_W_DEF = 8;

  localparam logic M_DMA  = 1'b0;
  localparam logic M_HOST = 1'b1;

  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // Lock state owned by the given master index.
  function automatic arb_state_t lock_state(input logic idx);
    return (idx == M_HOST) ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester handshakes plus the memory-side pins of the arbiter.
// slave = arbiter side, master = requesters/memory side.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req0, req1;
  logic              we0, we1;
  logic              lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    input  mem_rd_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output mem_we, mem_wr_addr, mem_wr_data, mem_re, mem_rd_addr
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    output mem_rd_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  mem_we, mem_wr_addr, mem_wr_data, mem_re, mem_rd_addr
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the master that did not
// win last time is chosen.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);
  assign grant_valid = |eligible;
  assign grant_idx   = (&eligible) ? ~last : eligible[M_HOST];
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter with burst lock in front of a 1W/1R memory.
// Optional saturating grant/conflict counters under `MEM_ARB_STATS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef MEM_ARB_STATS_EN
  ,
  parameter int STAT_W = STAT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rstn,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] gnt_cnt0,
  output logic [STAT_W-1:0] gnt_cnt1,
  output logic [STAT_W-1:0] conflict_cnt
`endif
);
  arb_state_t        state_reg, state_next;
  logic              last_reg, last_next;
  logic [1:0]        gnt_reg, gnt_next;
  logic [1:0]        rvalid_reg, rvalid_next;
  logic              mem_we_reg, mem_we_next;
  logic              mem_re_reg, mem_re_next;
  logic              rd_tag_reg, rd_tag_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;

  logic [1:0]        req_v, pend, eligible;
  logic              grant_valid, grant_idx;
  logic              sel_we, sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A master is masked in the cycle its grant is visible, so it cannot be granted twice.
  assign req_v = {bus.req1, bus.req0};
  assign pend  = req_v & ~gnt_reg;

  always_comb begin
    eligible = 2'b00;
    unique case (state_reg)
      OPEN:    eligible = pend;
      LOCK0:   eligible = pend & 2'b01;
      LOCK1:   eligible = pend & 2'b10;
      default: eligible = 2'b00;
    endcase
  end

  rr_pick2 u_pick (
    .eligible    (eligible),
    .last        (last_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_we    = grant_idx ? bus.we1    : bus.we0;
  assign sel_lock  = grant_idx ? bus.lock1  : bus.lock0;
  assign sel_addr  = grant_idx ? bus.addr1  : bus.addr0;
  assign sel_wdata = grant_idx ? bus.wdata1 : bus.wdata0;

  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    gnt_next     = 2'b00;
    mem_we_next  = 1'b0;
    mem_re_next  = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    rd_addr_next = rd_addr_reg;
    rd_tag_next  = rd_tag_reg;
    if (grant_valid) begin
      gnt_next[grant_idx] = 1'b1;
      last_next           = grant_idx;
      state_next          = sel_lock ? lock_state(grant_idx) : OPEN;
      if (sel_we) begin
        mem_we_next  = 1'b1;
        wr_addr_next = sel_addr;
        wr_data_next = sel_wdata;
      end else begin
        mem_re_next  = 1'b1;
        rd_addr_next = sel_addr;
        rd_tag_next  = grant_idx;
      end
    end
  end

  // Read data returns one cycle after mem_re to whichever master the tag names.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
    assign rvalid_next[gi] = mem_re_reg && (rd_tag_reg == 1'(gi));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= OPEN;
      last_reg    <= M_HOST;
      gnt_reg     <= 2'b00;
      rvalid_reg  <= 2'b00;
      mem_we_reg  <= 1'b0;
      mem_re_reg  <= 1'b0;
      rd_tag_reg  <= 1'b0;
      wr_addr_reg <= '0;
      rd_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      gnt_reg     <= gnt_next;
      rvalid_reg  <= rvalid_next;
      mem_we_reg  <= mem_we_next;
      mem_re_reg  <= mem_re_next;
      rd_tag_reg  <= rd_tag_next;
      wr_addr_reg <= wr_addr_next;
      rd_addr_reg <= rd_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  assign bus.gnt0        = gnt_reg[0];
  assign bus.gnt1        = gnt_reg[1];
  assign bus.rvalid0     = rvalid_reg[0];
  assign bus.rvalid1     = rvalid_reg[1];
  assign bus.rdata       = bus.mem_rd_data;
  assign bus.mem_we      = mem_we_reg;
  assign bus.mem_wr_addr = wr_addr_reg;
  assign bus.mem_wr_data = wr_data_reg;
  assign bus.mem_re      = mem_re_reg;
  assign bus.mem_rd_addr = rd_addr_reg;

`ifdef MEM_ARB_STATS_EN
  logic [2:0]        stat_inc;
  logic [STAT_W-1:0] stat_cnt_reg [3];

  // Conflict: a real tie, or the non-owner waiting on a lock.
  assign stat_inc[0] = grant_valid && (grant_idx == M_DMA);
  assign stat_inc[1] = grant_valid && (grant_idx == M_HOST);
  assign stat_inc[2] = ((state_reg == OPEN) && (&pend)) ||
                       ((state_reg == LOCK0) && pend[1]) ||
                       ((state_reg == LOCK1) && pend[0]);

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        stat_cnt_reg[gi] <= '0;
      end else if (stat_clr) begin
        stat_cnt_reg[gi] <= '0;
      end else if (stat_inc[gi] && (stat_cnt_reg[gi] != '1)) begin
        stat_cnt_reg[gi] <= stat_cnt_reg[gi] + STAT_W'(1);
      end
    end
  end

  assign gnt_cnt0     = stat_cnt_reg[0];
  assign gnt_cnt1     = stat_cnt_reg[1];
  assign conflict_cnt = stat_cnt_reg[2];
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences, and a randomized run against a rule-level model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic       stat_clr;
  logic [7:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .gnt_cnt0     (gnt_cnt0),
    .gnt_cnt1     (gnt_cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  // 16x8 memory: registered write, registered read, plus a bench preload port.
  logic [7:0] mem [16];
  logic       pre_en;
  logic [3:0] pre_addr;
  logic [7:0] pre_data;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.mem_we) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_re) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.lock0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    idle_inputs();
    pre_en = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    pre_en = 1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 0;
  endtask

  typedef struct {
    logic       r0, r1, w0, w1;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    logic       e_g0, e_g1, e_we, e_re;
    logic [3:0] e_addr;
    logic [7:0] e_wd;
  } vec_t;
  vec_t vecs [6];

  // Random-run master and model state
  logic       m_req [2], m_we [2], m_lock [2];
  logic [3:0] m_addr [2];
  logic [7:0] m_data [2];
  logic [7:0] ref_mem [16];

  task automatic drive_masters();
    bus.req0 = m_req[0]; bus.we0 = m_we[0]; bus.lock0 = m_lock[0];
    bus.addr0 = m_addr[0]; bus.wdata0 = m_data[0];
    bus.req1 = m_req[1]; bus.we1 = m_we[1]; bus.lock1 = m_lock[1];
    bus.addr1 = m_addr[1]; bus.wdata1 = m_data[1];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    pre_en = 0; pre_addr = 0; pre_data = 0;
`ifdef MEM_ARB_STATS_EN
    stat_clr = 0;
`endif
    vecs[0] = '{1,0,1,0, 4'h3,4'h0, 8'hA1,8'h00, 1,0,1,0, 4'h3, 8'hA1};
    vecs[1] = '{0,1,0,1, 4'h0,4'h6, 8'h00,8'h66, 0,1,1,0, 4'h6, 8'h66};
    vecs[2] = '{1,0,0,0, 4'h5,4'h0, 8'h00,8'h00, 1,0,0,1, 4'h5, 8'h00};
    vecs[3] = '{0,1,0,0, 4'h0,4'h9, 8'h00,8'h00, 0,1,0,1, 4'h9, 8'h00};
    vecs[4] = '{1,1,1,1, 4'h1,4'h2, 8'hB2,8'hC3, 1,0,1,0, 4'h1, 8'hB2};
    vecs[5] = '{1,1,0,1, 4'h4,4'hE, 8'h00,8'h3C, 1,0,0,1, 4'h4, 8'h00};

    // Reset state
    do_reset();
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
    chk("rst_mem_en", {bus.mem_we, bus.mem_re}, 0);
    chk("rst_mem_addr", {bus.mem_wr_addr, bus.mem_rd_addr, bus.mem_wr_data}, 0);

    // Single command from a fresh reset: grant and memory pins in T+1
    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.req0 = vecs[i].r0; bus.we0 = vecs[i].w0; bus.addr0 = vecs[i].a0; bus.wdata0 = vecs[i].d0;
      bus.req1 = vecs[i].r1; bus.we1 = vecs[i].w1; bus.addr1 = vecs[i].a1; bus.wdata1 = vecs[i].d1;
      tick();
      $display("vec %0d: gnt=%b%b we=%b re=%b", i, bus.gnt1, bus.gnt0, bus.mem_we, bus.mem_re);
      chk($sformatf("vec%0d_gnt0", i), bus.gnt0, vecs[i].e_g0);
      chk($sformatf("vec%0d_gnt1", i), bus.gnt1, vecs[i].e_g1);
      chk($sformatf("vec%0d_we", i), bus.mem_we, vecs[i].e_we);
      chk($sformatf("vec%0d_re", i), bus.mem_re, vecs[i].e_re);
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d_wr_addr", i), bus.mem_wr_addr, vecs[i].e_addr);
        chk($sformatf("vec%0d_wr_data", i), bus.mem_wr_data, vecs[i].e_wd);
      end else begin
        chk($sformatf("vec%0d_rd_addr", i), bus.mem_rd_addr, vecs[i].e_addr);
      end
      idle_inputs();
      tick();
      tick();
    end

    // Tie after reset: m0 first, then m1
    do_reset();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'h1; bus.wdata0 = 8'hB2;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 4'h2; bus.wdata1 = 8'hC3;
    tick();
    $display("tie T+1: gnt=%b%b wr %h:%h", bus.gnt1, bus.gnt0, bus.mem_wr_addr, bus.mem_wr_data);
    chk("tie_t1_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
    chk("tie_t1_wr", {bus.mem_we, bus.mem_wr_addr, bus.mem_wr_data}, {1'b1, 4'h1, 8'hB2});
    bus.req0 = 0;
    tick();
    $display("tie T+2: gnt=%b%b wr %h:%h", bus.gnt1, bus.gnt0, bus.mem_wr_addr, bus.mem_wr_data);
    chk("tie_t2_gnt", {bus.gnt1, bus.gnt0}, 2'b10);
    chk("tie_t2_wr", {bus.mem_we, bus.mem_wr_addr, bus.mem_wr_data}, {1'b1, 4'h2, 8'hC3});
    bus.req1 = 0;
    tick();

    // Read return to the issuing master
    do_reset();
    preload(4'h5, 8'hD4);
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'h5;
    tick();
    chk("rd_t1_gnt", {bus.gnt1, bus.gnt0}, 2'b10);
    chk("rd_t1_mem", {bus.mem_re, bus.mem_we, bus.mem_rd_addr}, {1'b1, 1'b0, 4'h5});
    bus.req1 = 0;
    tick();
    $display("read: rvalid=%b%b rdata=%h", bus.rvalid1, bus.rvalid0, bus.rdata);
    chk("rd_t2_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b10);
    chk("rd_t2_rdata", bus.rdata, 8'hD4);

    // Read-after-write to the same address in consecutive cycles sees new data
    do_reset();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'h7; bus.wdata0 = 8'h5E;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'h7;
    tick();
    bus.req0 = 0;
    tick();
    chk("raw_rd_gnt", {bus.gnt1, bus.mem_re, bus.mem_rd_addr}, {1'b1, 1'b1, 4'h7});
    bus.req1 = 0;
    tick();
    $display("raw: rvalid=%b%b rdata=%h", bus.rvalid1, bus.rvalid0, bus.rdata);
    chk("raw_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b10);
    chk("raw_rdata", bus.rdata, 8'h5E);

    // Lock burst: m1 held off until m0's unlocked 4th write
    begin
      int g0_cyc [4];
      int n0 = 0;
      int g1_first = -1;
      do_reset();
      for (int k = 0; k < 4; k++) g0_cyc[k] = -1;
      bus.req0 = 1; bus.we0 = 1; bus.lock0 = 1; bus.addr0 = 4'h8; bus.wdata0 = 8'h10;
      bus.req1 = 1; bus.we1 = 1; bus.lock1 = 0; bus.addr1 = 4'hF; bus.wdata1 = 8'h5A;
      for (int c = 1; c <= 20; c++) begin
        tick();
        if (bus.gnt0 && n0 < 4) begin
          g0_cyc[n0] = c;
          $display("lock: gnt0 #%0d at cycle %0d addr=%h", n0, c, bus.mem_wr_addr);
          n0++;
          if (n0 == 4) bus.req0 = 0;
          else begin
            bus.addr0 = 4'(8 + n0); bus.wdata0 = 8'(16 + n0); bus.lock0 = (n0 < 3);
          end
        end
        if (bus.gnt1 && g1_first < 0) begin
          g1_first = c;
          $display("lock: gnt1 at cycle %0d", c);
          bus.req1 = 0;
        end
      end
      chk("lock_n0", n0, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("lock_gnt0_cyc%0d", k), g0_cyc[k], 2 * k + 1);
      chk("lock_gnt1_cyc", g1_first, 8);
    end

    // Reset during an in-flight read
    do_reset();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'h5;
    tick();
    chk("rstrd_issue", {bus.gnt0, bus.mem_re, bus.mem_rd_addr}, {1'b1, 1'b1, 4'h5});
    bus.req0 = 0;
    #2;
    rstn = 0;
    #1;
    chk("rstrd_outs", {bus.gnt0, bus.gnt1, bus.mem_we, bus.mem_re, bus.rvalid0, bus.rvalid1}, 0);
    chk("rstrd_addr", {bus.mem_wr_addr, bus.mem_rd_addr, bus.mem_wr_data}, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rstrd_rvalid%0d", k), {bus.rvalid1, bus.rvalid0}, 0);
    end
    rstn = 1;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 4'hC; bus.wdata1 = 8'h77;
    tick();
    $display("post-reset: gnt=%b%b", bus.gnt1, bus.gnt0);
    chk("rstrd_post_gnt", {bus.gnt1, bus.gnt0}, 2'b10);
    chk("rstrd_post_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
    bus.req1 = 0;
    tick();

    // Randomized traffic against a rule-level model
    begin
      int owner = -1;
      int last = 1;
      logic [1:0] eg = 2'b00;
      logic e_we = 0, e_re = 0, e_tag = 0;
      logic [3:0] e_addr = 0;
      logic [7:0] e_wd = 0, e_rdata = 0;
      logic rp_valid = 0, rp_tag = 0;
      logic [7:0] rp_data = 0;
      do_reset();
      for (int a = 0; a < 16; a++) begin
        ref_mem[a] = 8'($urandom_range(0, 255));
        preload(4'(a), ref_mem[a]);
      end
      for (int i = 0; i < 2; i++) begin
        m_req[i] = 0; m_we[i] = 0; m_lock[i] = 0; m_addr[i] = 0; m_data[i] = 0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
        logic gs [2];
        int w;
        logic p0, p1;
        chk("rnd_gnt", {bus.gnt1, bus.gnt0}, eg);
        chk("rnd_en", {bus.mem_we, bus.mem_re}, {e_we, e_re});
        if (e_we) chk("rnd_wr", {bus.mem_wr_addr, bus.mem_wr_data}, {e_addr, e_wd});
        if (e_re) chk("rnd_rd_addr", bus.mem_rd_addr, e_addr);
        chk("rnd_rvalid", {bus.rvalid1, bus.rvalid0},
            {rp_valid && rp_tag, rp_valid && !rp_tag});
        if (rp_valid) chk("rnd_rdata", bus.rdata, rp_data);
        rp_valid = e_re; rp_tag = e_tag; rp_data = e_rdata;

        gs[0] = bus.gnt0; gs[1] = bus.gnt1;
        for (int i = 0; i < 2; i++) begin
          if (gs[i]) m_req[i] = 0;
          if (!m_req[i] && $urandom_range(0, 1) == 1) begin
            m_req[i] = 1;
            m_we[i] = 1'($urandom_range(0, 1));
            m_lock[i] = ($urandom_range(0, 3) == 0);
            m_addr[i] = 4'($urandom_range(0, 15));
            m_data[i] = 8'($urandom_range(0, 255));
          end
        end
        drive_masters();

        p0 = m_req[0] && !eg[0];
        p1 = m_req[1] && !eg[1];
        w = -1;
        if (owner == 0) w = p0 ? 0 : -1;
        else if (owner == 1) w = p1 ? 1 : -1;
        else if (p0 && p1) w = 1 - last;
        else if (p0) w = 0;
        else if (p1) w = 1;
        eg = 2'b00; e_we = 0; e_re = 0;
        if (w >= 0) begin
          eg[w] = 1'b1;
          last = w;
          owner = m_lock[w] ? w : -1;
          e_addr = m_addr[w];
          if (m_we[w]) begin
            e_we = 1; e_wd = m_data[w];
            ref_mem[m_addr[w]] = m_data[w];
          end else begin
            e_re = 1; e_tag = 1'(w);
            e_rdata = ref_mem[m_addr[w]];
          end
          $display("rnd cyc %0d: m%0d %s addr=%h data=%h lock=%0d", cyc, w,
                   m_we[w] ? "WR" : "RD", m_addr[w], m_we[w] ? m_data[w] : e_rdata, m_lock[w]);
        end
        tick();
      end
      idle_inputs();
      tick();
      tick();
    end

`ifdef MEM_ARB_STATS_EN
    // Saturating grant counter and clear
    begin
      int n = 0;
      do_reset();
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 0; bus.wdata0 = 0;
      for (int c = 0; c < 1000 && n < 300; c++) begin
        tick();
        if (bus.gnt0) begin
          n++;
          bus.addr0 = 4'(n); bus.wdata0 = 8'(n);
        end
      end
      bus.req0 = 0;
      tick();
      $display("stats: %0d grants, gnt_cnt0=%h", n, gnt_cnt0);
      chk("stat_grants", n, 300);
      chk("stat_sat", gnt_cnt0, 8'hFF);
      chk("stat_cnt1", gnt_cnt1, 8'h00);
      stat_clr = 1;
      tick();
      stat_clr = 0;
      chk("stat_clr", gnt_cnt0, 8'h00);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
